ram_port_arbiter: RTL and testbench

RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

---
 rtl/ram_port_arbiter.sv | 119 +++++++++++
 tb/tb_ram_port_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_port_arbiter.sv
// Shares one RAM port between instruction fetch (I) and data (D) requesters.
// Ports: clock/reset; i_cmd_*/i_rsp_* fetch; d_cmd_*/d_rsp_* data; ram_* RAM port.
module ram_port_arbiter #(
  parameter logic [63:0] BASE_ADDR = 64'h8000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        i_cmd_valid,
  output logic        i_cmd_ready,
  input  logic [63:0] i_cmd_addr,
  output logic        i_rsp_valid,
  output logic [31:0] i_rsp_data,
  input  logic        d_cmd_valid,
  output logic        d_cmd_ready,
  input  logic [63:0] d_cmd_addr,
  input  logic        d_cmd_wen,
  input  logic [63:0] d_cmd_wdata,
  input  logic [7:0]  d_cmd_wstrb,
  output logic        d_rsp_valid,
  output logic [63:0] d_rsp_data,
  output logic        ram_en,
  output logic [27:0] ram_idx,
  output logic        ram_wen,
  output logic [63:0] ram_wdata,
  output logic [63:0] ram_wmask,
  input  logic [63:0] ram_rdata
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;
  localparam logic GNT_I = 1'b0;
  localparam logic GNT_D = 1'b1;

  logic [0:0]  state;
  logic        last_grant;
  logic        owner;
  logic        hi_word;
  logic [31:0] i_hold;
  logic [63:0] d_hold;

  logic        idle;
  logic        gnt_d;
  logic        i_acc;
  logic        d_acc;
  logic        rd_acc;
  logic [63:0] sel_addr;
  logic [63:0] off;
  logic [31:0] i_word;
  logic        unused_off;

  // Both valid: the side that did not win last time takes the port.
  always_comb begin
    idle     = (state == IDLE) && !reset;
    gnt_d    = d_cmd_valid &&
               (!i_cmd_valid || last_grant == GNT_I);
    d_acc    = idle && gnt_d;
    i_acc    = idle && i_cmd_valid && !gnt_d;
    rd_acc   = i_acc || (d_acc && !d_cmd_wen);
    sel_addr = d_acc ? d_cmd_addr : i_cmd_addr;
    // Wraps modulo 2^64 for addresses below the base.
    off      = sel_addr - BASE_ADDR;
  end

  assign unused_off = ^{off[63:31], off[1:0]};

  always_comb begin
    i_cmd_ready = i_acc;
    d_cmd_ready = d_acc;
    ram_en      = i_acc || d_acc;
    ram_idx     = ram_en ? off[30:3] : 28'd0;
    ram_wen     = d_acc && d_cmd_wen;
    ram_wdata   = ram_wen ? d_cmd_wdata : 64'd0;
    ram_wmask   = 64'd0;
    for (int k = 0; k < 8; k++) begin
      ram_wmask[8*k +: 8] = {8{ram_wen && d_cmd_wstrb[k]}};
    end
  end

  always_comb begin
    i_word      = hi_word ? ram_rdata[63:32]
                          : ram_rdata[31:0];
    i_rsp_valid = (state == WAIT) && !reset &&
                  (owner == GNT_I);
    d_rsp_valid = (state == WAIT) && !reset &&
                  (owner == GNT_D);
    i_rsp_data  = i_rsp_valid ? i_word : i_hold;
    d_rsp_data  = d_rsp_valid ? ram_rdata : d_hold;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= GNT_I;
      owner      <= GNT_I;
      hi_word    <= 1'b0;
      i_hold     <= 32'd0;
      d_hold     <= 64'd0;
    end else begin
      if (i_acc || d_acc) begin
        last_grant <= d_acc ? GNT_D : GNT_I;
      end
      if (rd_acc) begin
        state   <= WAIT;
        owner   <= d_acc ? GNT_D : GNT_I;
        hi_word <= off[2];
      end
      if (state == WAIT) begin
        state <= IDLE;
      end
      if (i_rsp_valid) begin
        i_hold <= i_word;
      end
      if (d_rsp_valid) begin
        d_hold <= ram_rdata;
      end
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter: directed steps then random
// traffic against a transaction-level model of the shared port.
module tb_ram_port_arbiter;

  localparam logic [63:0] BASE = 64'h8000_0000;

  logic        clock = 1'b0;
  logic        reset;
  logic        i_cmd_valid;
  logic        i_cmd_ready;
  logic [63:0] i_cmd_addr;
  logic        i_rsp_valid;
  logic [31:0] i_rsp_data;
  logic        d_cmd_valid;
  logic        d_cmd_ready;
  logic [63:0] d_cmd_addr;
  logic        d_cmd_wen;
  logic [63:0] d_cmd_wdata;
  logic [7:0]  d_cmd_wstrb;
  logic        d_rsp_valid;
  logic [63:0] d_rsp_data;
  logic        ram_en;
  logic [27:0] ram_idx;
  logic        ram_wen;
  logic [63:0] ram_wdata;
  logic [63:0] ram_wmask;
  logic [63:0] ram_rdata;

  always #5 clock = ~clock;

  ram_port_arbiter #(.BASE_ADDR(BASE)) dut (
    .clock       (clock),
    .reset       (reset),
    .i_cmd_valid (i_cmd_valid),
    .i_cmd_ready (i_cmd_ready),
    .i_cmd_addr  (i_cmd_addr),
    .i_rsp_valid (i_rsp_valid),
    .i_rsp_data  (i_rsp_data),
    .d_cmd_valid (d_cmd_valid),
    .d_cmd_ready (d_cmd_ready),
    .d_cmd_addr  (d_cmd_addr),
    .d_cmd_wen   (d_cmd_wen),
    .d_cmd_wdata (d_cmd_wdata),
    .d_cmd_wstrb (d_cmd_wstrb),
    .d_rsp_valid (d_rsp_valid),
    .d_rsp_data  (d_rsp_data),
    .ram_en      (ram_en),
    .ram_idx     (ram_idx),
    .ram_wen     (ram_wen),
    .ram_wdata   (ram_wdata),
    .ram_wmask   (ram_wmask),
    .ram_rdata   (ram_rdata)
  );

  typedef struct {
    bit own_d;
    bit hi;
  } pend_t;

  pend_t       q[$];
  int          checks = 0;
  int          failures = 0;
  bit          last_d = 1'b0;
  logic [31:0] i_hold = 32'd0;
  logic [63:0] d_hold = 64'd0;
  int          wait_i = 0;
  int          wait_d = 0;
  int          max_wait = 0;

  logic        s_iready, s_dready, s_irv, s_drv, s_rwen;
  logic [27:0] s_idx;
  logic [63:0] s_wmask;
  logic [31:0] s_idata;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic step(input bit rst,
                      input bit iv, input logic [63:0] ia,
                      input bit dv, input logic [63:0] da,
                      input bit dw, input logic [63:0] wd,
                      input logic [7:0] ws,
                      input logic [63:0] rd);
    bit          busy, gi, gd, ri, rdv;
    logic [63:0] a, off, mask, e_idx;
    logic [31:0] ei;
    logic [63:0] ed;
    pend_t       p;
    reset = rst; i_cmd_valid = iv; i_cmd_addr = ia;
    d_cmd_valid = dv; d_cmd_addr = da; d_cmd_wen = dw;
    d_cmd_wdata = wd; d_cmd_wstrb = ws; ram_rdata = rd;
    busy = rst || (q.size() != 0);
    gi = 1'b0; gd = 1'b0;
    if (!busy) begin
      if (iv && dv) begin
        gd = !last_d; gi = last_d;
      end else begin
        gi = iv; gd = dv;
      end
    end
    a = gd ? da : ia;
    off = a - BASE;
    e_idx = (gi || gd) ? ((off / 8) % 64'h1000_0000) : 64'd0;
    mask = 64'd0;
    if (gd && dw)
      for (int k = 0; k < 8; k++)
        if (ws[k]) mask = mask | (64'hFF << (8 * k));
    ri = 1'b0; rdv = 1'b0; ei = i_hold; ed = d_hold;
    if (!rst && q.size() != 0) begin
      p = q[0];
      if (p.own_d) begin
        rdv = 1'b1; ed = rd;
      end else begin
        ri = 1'b1;
        ei = p.hi ? 32'(rd / 64'h1_0000_0000) : 32'(rd);
      end
    end
    #1;
    chk("i_cmd_ready", 64'(i_cmd_ready), 64'(gi));
    chk("d_cmd_ready", 64'(d_cmd_ready), 64'(gd));
    chk("ram_en", 64'(ram_en), 64'(gi || gd));
    chk("ram_idx", 64'(ram_idx), e_idx);
    chk("ram_wen", 64'(ram_wen), 64'(gd && dw));
    chk("ram_wdata", ram_wdata, (gd && dw) ? wd : 64'd0);
    chk("ram_wmask", ram_wmask, mask);
    chk("i_rsp_valid", 64'(i_rsp_valid), 64'(ri));
    chk("d_rsp_valid", 64'(d_rsp_valid), 64'(rdv));
    chk("i_rsp_data", 64'(i_rsp_data), 64'(ei));
    chk("d_rsp_data", d_rsp_data, ed);
    s_iready = i_cmd_ready; s_dready = d_cmd_ready;
    s_irv = i_rsp_valid; s_drv = d_rsp_valid;
    s_rwen = ram_wen; s_idx = ram_idx;
    s_wmask = ram_wmask; s_idata = i_rsp_data;
    if (!rst && iv && !gi) wait_i++; else wait_i = 0;
    if (!rst && dv && !gd) wait_d++; else wait_d = 0;
    if (wait_i > max_wait) max_wait = wait_i;
    if (wait_d > max_wait) max_wait = wait_d;
    @(posedge clock);
    if (rst) begin
      q.delete();
      last_d = 1'b0; i_hold = 32'd0; d_hold = 64'd0;
    end else begin
      if (ri || rdv) begin
        void'(q.pop_front());
        i_hold = ei; d_hold = ed;
      end
      if (gi || gd) begin
        last_d = gd;
        if (gi || !dw) begin
          p.own_d = gd;
          p.hi = ((off / 4) % 2) == 1;
          q.push_back(p);
        end
      end
    end
    @(negedge clock);
  endtask

  task automatic idle_step(input bit rst, input logic [63:0] rd);
    step(rst, 0, 64'd0, 0, 64'd0, 0, 64'd0, 8'd0, rd);
  endtask

  initial begin
    logic [63:0] ia, da;
    reset = 1'b1; i_cmd_valid = 1'b0; i_cmd_addr = 64'd0;
    d_cmd_valid = 1'b0; d_cmd_addr = 64'd0; d_cmd_wen = 1'b0;
    d_cmd_wdata = 64'd0; d_cmd_wstrb = 8'd0; ram_rdata = 64'd0;
    repeat (2) @(posedge clock);
    @(negedge clock);

    // reset state, including requests held during reset
    step(1, 1, BASE, 1, BASE, 0, 64'd0, 8'd0, 64'd0);
    chk("rst_iready", 64'(s_iready), 64'd0);

    // I-only fetch of the upper word
    step(0, 1, 64'h8000_0004, 0, 64'd0, 0, 64'd0, 8'd0, 64'd0);
    chk("fetch_idx", 64'(s_idx), 64'd0);
    idle_step(0, 64'h1111_2222_3333_4444);
    chk("fetch_rv", 64'(s_irv), 64'd1);
    chk("fetch_data", 64'(s_idata), 64'h1111_2222);

    // first conflict after reset goes to D, then I
    idle_step(1, 64'd0);
    step(0, 1, BASE, 1, BASE + 8, 0, 64'd0, 8'd0, 64'd0);
    chk("conf_d_first", 64'(s_dready), 64'd1);
    step(0, 1, BASE, 0, 64'd0, 0, 64'd0, 8'd0, 64'hA5A5);
    chk("conf_d_rsp", 64'(s_drv), 64'd1);
    step(0, 1, BASE, 0, 64'd0, 0, 64'd0, 8'd0, 64'd0);
    chk("conf_i_next", 64'(s_iready), 64'd1);
    idle_step(0, 64'h7777_0000_8888_0000);

    // D write: single cycle, no response
    step(0, 0, 64'd0, 1, 64'h8000_0018, 1,
         64'hDEAD_BEEF_CAFE_F00D, 8'h0F, 64'd0);
    chk("wr_idx", 64'(s_idx), 64'd3);
    chk("wr_wen", 64'(s_rwen), 64'd1);
    chk("wr_mask", s_wmask, 64'h0000_0000_FFFF_FFFF);
    step(0, 1, BASE + 64'h40, 0, 64'd0, 0, 64'd0, 8'd0, 64'd0);
    chk("wr_no_rsp", 64'(s_drv), 64'd0);
    chk("wr_i_ready", 64'(s_iready), 64'd1);
    idle_step(0, 64'h1234);

    // sustained dual reads
    max_wait = 0;
    for (int c = 0; c < 8; c++)
      step(0, 1, BASE + 64'h100, 1, BASE + 64'h208, 0,
           64'd0, 8'd0, {$urandom, $urandom});
    chk("max_wait_le4", 64'(max_wait <= 4), 64'd1);
    idle_step(0, 64'd0);

    // reset during WAIT drops the response
    step(0, 1, BASE + 64'h10, 0, 64'd0, 0, 64'd0, 8'd0, 64'd0);
    idle_step(1, 64'hFFFF);
    step(0, 1, BASE + 64'h14, 0, 64'd0, 0, 64'd0, 8'd0, 64'd0);
    chk("rstw_no_rsp", 64'(s_irv), 64'd0);
    chk("rstw_ready", 64'(s_iready), 64'd1);
    idle_step(0, 64'h55);

    // random traffic
    for (int n = 0; n < 400; n++) begin
      ia = BASE + 64'({$urandom_range(0, 65535), 2'b00});
      da = BASE + 64'($urandom_range(0, 1048575));
      if ($urandom_range(0, 15) == 0) ia = 64'($urandom) & ~64'd3;
      if ($urandom_range(0, 15) == 0) da = {$urandom, $urandom};
      step($urandom_range(0, 39) == 0,
           $urandom_range(0, 2) != 0, ia,
           $urandom_range(0, 2) != 0, da,
           $urandom_range(0, 1) == 1, {$urandom, $urandom},
           8'($urandom), {$urandom, $urandom});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
